ins_mem_loader: RTL and testbench

Boot-time program loader that is the writer side of the instruction memory the CPU datapath reads. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into instruction memory at sequential byte addresses. While loading, it holds the CPU stalled, and it reports completion or error.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/ins_mem_loader_pack.sv | 56 +++++
 rtl/ins_mem_loader.sv | 210 +++++++++++++++++++++
 tb/tb_ins_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// stream framing constants and a small state-classification helper.
package loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_LEN_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_CHK    = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERR    = 3'd6;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_STEP  = 4;

  // States in which the loader is consuming stream bytes.
  function automatic logic is_loading(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/ins_mem_loader_pack.sv
// Byte-to-word packer: shifts accepted bytes MSB first into a 32-bit word and
// emits a registered one-cycle word_ready pulse after the 4th byte.
module ins_mem_loader_pack (
  input  logic        CLK,
  input  logic        clrn,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_ready,
  output logic [31:0] word
);
  import loader_pkg::*;

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shreg_q, shreg_d;
  logic [31:0] word_q, word_d;
  logic        ready_q, ready_d;

  assign last_byte  = (cnt_q == 2'(WORD_BYTES - 1));
  assign word_ready = ready_q;
  assign word       = word_q;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    ready_d = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (byte_en) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = {shreg_q[15:0], byte_in};
      if (last_byte) begin
        word_d  = {shreg_q, byte_in};
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!clrn) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/ins_mem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream in, word
// writes out, CPU held in stall until done. LOADER_CHECKSUM_EN adds a trailing XOR byte.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN_HI  | taking length byte N[15:8]
// LEN_LO  | taking length byte N[7:0], range check
// DATA    | packing data bytes into words
// CHK     | taking the XOR checksum byte (LOADER_CHECKSUM_EN only)
// DONE    | load complete, CPU released
// ERR     | load failed, CPU held
module ins_mem_loader #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        CLK,
  input  logic        clrn,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);
  import loader_pkg::*;

  localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] words_left_q, words_left_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [15:0] word_count_q, word_count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic        accept;
  logic        restart;
  logic [15:0] len_n;
  logic        last_byte;
  logic        word_ready;
  logic [31:0] word;

  assign accept = in_valid && in_ready_q;
  assign len_n  = {len_hi_q, in_data};

  ins_mem_loader_pack u_pack (
    .CLK        (CLK),
    .clrn       (clrn),
    .clear      (restart),
    .byte_en    (accept && (state_q == ST_DATA)),
    .byte_in    (in_data),
    .last_byte  (last_byte),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    words_left_d = words_left_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    done_d       = done_q;
    err_d        = err_q;
    hold_d       = hold_q;
    restart      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_LEN_HI;
        end else if ((state_q == ST_DONE) && word_ready) begin
          // Final word is being written now; release the CPU on the next cycle.
          done_d = 1'b1;
          hold_d = 1'b0;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          words_left_d = len_n;
          if (len_n > DEPTH_N) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept && last_byte) begin
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          if (in_data == chk_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    if (accept && ((state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA)))
      chk_d = chk_q ^ in_data;
`endif

    if (word_ready) begin
      wr_addr_d    = wr_addr_q + 32'(ADDR_STEP);
      word_count_d = word_count_q + 16'd1;
    end

    // A restart wins over a write retiring in the same cycle.
    if (restart) begin
      wr_addr_d    = '0;
      word_count_d = '0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      hold_d       = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      chk_d        = '0;
`endif
    end

    in_ready_d = is_loading(state_d);
  end

  always_ff @(posedge CLK) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      len_hi_q     <= '0;
      words_left_q <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      hold_q       <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      len_hi_q     <= len_hi_d;
      words_left_q <= words_left_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = word_ready;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = word;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: hand-computed streams, write log captured
// on the falling edge, every comparison routed through check().
module tb_ins_mem_loader;

  logic        CLK = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  always #5 CLK = ~CLK;

  ins_mem_loader #(.DEPTH_WORDS(64)) dut (
    .CLK        (CLK),
    .clrn       (clrn),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          nwr = 0;
  int          base = 0;
  logic [31:0] log_addr [16];
  logic [31:0] log_data [16];
  logic [7:0]  sq [$];

  always @(negedge CLK) begin
    if (wr_en) begin
      if (nwr < 16) begin
        log_addr[nwr] = wr_addr;
        log_data[nwr] = wr_data;
      end
      nwr = nwr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      rdy = in_ready;
      @(posedge CLK);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_stream(input logic throttle);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < sq.size(); i++) begin
      send_byte(sq[i]);
      acc = acc ^ sq[i];
      if (throttle) begin
        in_valid = 1'b0;
        tick();
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(acc);
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || err) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("end_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    // Reset and idle behaviour
    clrn = 1'b0;
    tick();
    tick();
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_wr_en",      32'(wr_en),      32'd0);
    check("rst_wr_addr",    wr_addr,         32'd0);
    check("rst_wr_data",    wr_data,         32'd0);
    check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    check("rst_done",       32'(done),       32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    clrn = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    tick();
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_no_write", 32'(nwr),      32'd0);

    // Two-word load; start arrives with a byte still offered
    base = nwr;
    pulse_start();
    check("start_in_ready", 32'(in_ready), 32'd1);
    sq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_stream(1'b0);
`ifndef LOADER_CHECKSUM_EN
    check("w2_wr_en",    32'(wr_en),    32'd1);
    check("w2_wr_addr",  wr_addr,       32'd4);
    check("w2_wr_data",  wr_data,       32'h9ABCDEF0);
    check("w2_done_lag", 32'(done),     32'd0);
    check("w2_hold_lag", 32'(cpu_hold), 32'd1);
    tick();
    check("w2_wr_en_off", 32'(wr_en), 32'd0);
    check("w2_addr_next", wr_addr,    32'd8);
`else
    wait_end();
`endif
    check("w2_done",   32'(done),       32'd1);
    check("w2_hold",   32'(cpu_hold),   32'd0);
    check("w2_count",  32'(word_count), 32'd2);
    check("w2_nwr",    32'(nwr - base), 32'd2);
    check("w2_a0",     log_addr[base],     32'd0);
    check("w2_d0",     log_data[base],     32'h12345678);
    check("w2_a1",     log_addr[base + 1], 32'd4);
    check("w2_d1",     log_data[base + 1], 32'h9ABCDEF0);

    // Oversize length, then recovery
    base = nwr;
    pulse_start();
    check("ovr_restart_done", 32'(done),     32'd0);
    check("ovr_restart_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00);
    send_byte(8'h41);
    in_valid = 1'b0;
    check("ovr_err",      32'(err),      32'd1);
    check("ovr_done",     32'(done),     32'd0);
    check("ovr_hold",     32'(cpu_hold), 32'd1);
    check("ovr_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    tick();
    check("ovr_no_write", 32'(nwr - base), 32'd0);
    pulse_start();
    check("ovr_err_clr", 32'(err), 32'd0);
    sq = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(1'b0);
    wait_end();
    check("rec_done",  32'(done),       32'd1);
    check("rec_err",   32'(err),        32'd0);
    check("rec_count", 32'(word_count), 32'd1);
    check("rec_nwr",   32'(nwr - base), 32'd1);
    check("rec_a0",    log_addr[base],  32'd0);
    check("rec_d0",    log_data[base],  32'h11223344);

    // Throttled input
    base = nwr;
    pulse_start();
    sq = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(1'b1);
    wait_end();
    check("thr_done",  32'(done),       32'd1);
    check("thr_count", 32'(word_count), 32'd1);
    check("thr_nwr",   32'(nwr - base), 32'd1);
    check("thr_a0",    log_addr[base],  32'd0);
    check("thr_d0",    log_data[base],  32'hAABBCCDD);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    base = nwr;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    in_valid = 1'b0;
    wait_end();
    check("chk_ok_done", 32'(done),     32'd1);
    check("chk_ok_err",  32'(err),      32'd0);
    check("chk_ok_d0",   log_data[base], 32'h01020304);
    base = nwr;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h06);
    in_valid = 1'b0;
    wait_end();
    check("chk_bad_err",  32'(err),        32'd1);
    check("chk_bad_done", 32'(done),       32'd0);
    check("chk_bad_hold", 32'(cpu_hold),   32'd1);
    check("chk_bad_nwr",  32'(nwr - base), 32'd1);
    check("chk_bad_d0",   log_data[base],  32'h01020304);
`endif

    // Reset in the middle of the first word
    base = nwr;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    in_valid = 1'b0;
    clrn = 1'b0;
    tick();
    check("mid_in_ready", 32'(in_ready),   32'd0);
    check("mid_hold",     32'(cpu_hold),   32'd1);
    check("mid_done",     32'(done),       32'd0);
    check("mid_count",    32'(word_count), 32'd0);
    check("mid_wr_addr",  wr_addr,         32'd0);
    check("mid_wr_data",  wr_data,         32'd0);
    clrn = 1'b1;
    tick();
    tick();
    tick();
    check("mid_no_write", 32'(nwr - base), 32'd0);
    pulse_start();
    sq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stream(1'b0);
    wait_end();
    check("mid_re_done", 32'(done),       32'd1);
    check("mid_re_nwr",  32'(nwr - base), 32'd1);
    check("mid_re_a0",   log_addr[base],  32'd0);
    check("mid_re_d0",   log_data[base],  32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
